traffic_conflict_monitor: RTL and testbench

Fail-safe stage between the 2-way `traffic` controller and the physical lamp drivers. It takes the six controller lamp signals, passes legal combinations through with one register stage, and latches a fault on any persistent illegal combination. Latched faults drive both directions to flashing red until an explicit clear and a proven all-red recovery. It is the last logic before the lamps.

---
 rtl/traffic_pkg.sv | 35 +++
 rtl/traffic_flasher.sv | 40 ++++
 rtl/traffic_conflict_monitor.sv | 138 +++++++++++++
 tb/tb_traffic_conflict_monitor.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/traffic_pkg.sv
// Shared types and lamp-legality helper for the traffic lamp path.
// Lamp groups are packed as {R, Y, G}.
package traffic_pkg;

    typedef enum logic [1:0] {
        MONITOR,
        FAULT,
        RECOVER
    } state_t;

    localparam logic [1:0] NONE     = 2'd0;
    localparam logic [1:0] CONFLICT = 2'd1;
    localparam logic [1:0] MULTI    = 2'd2;
    localparam logic [1:0] DARK     = 2'd3;

    // Classify one sample of both groups; NONE means legal.
    function automatic logic [1:0] group_check(
        input logic [2:0] a,
        input logic [2:0] b
    );
        logic multi_a;
        logic multi_b;
        multi_a = (a[2] & a[1]) | (a[2] & a[0]) | (a[1] & a[0]);
        multi_b = (b[2] & b[1]) | (b[2] & b[0]) | (b[1] & b[0]);
        if ((|a[1:0]) && (|b[1:0]))
            return CONFLICT;
        else if (multi_a || multi_b)
            return MULTI;
        else if (a == 3'b000 || b == 3'b000)
            return DARK;
        else
            return NONE;
    endfunction

endpackage

// File: rtl/traffic_flasher.sv
// Fault flash phase generator: lit on the first enabled cycle,
// then toggling every FLASH_HALF cycles while enabled.
module traffic_flasher
#(
    parameter int FLASH_HALF = 8
)(
    input  logic clk,
    input  logic rst,
    input  logic en,
    output logic phase
);

    localparam int W = $clog2(FLASH_HALF) + 1;

    logic [W-1:0] cnt;
    logic         en_q;

    // Restart lit on a rising en, count half-periods while held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt   <= '0;
            phase <= 1'b1;
            en_q  <= 1'b0;
        end else begin
            en_q <= en;
            if (en && en_q) begin
                if (cnt >= W'(FLASH_HALF - 1)) begin
                    cnt   <= '0;
                    phase <= ~phase;
                end else begin
                    cnt <= cnt + W'(1);
                end
            end else begin
                cnt   <= '0;
                phase <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/traffic_conflict_monitor.sv
// Fail-safe lamp stage: registered pass-through of legal lamps,
// filtered fault latching, flashing red and all-red recovery.
module traffic_conflict_monitor
    import traffic_pkg::*;
#(
    parameter int FILTER_CYC = 4,
    parameter int FLASH_HALF = 8,
    parameter int CLEAR_HOLD = 16
)(
    input  logic       clk,
    input  logic       rst,
    input  logic       R1,
    input  logic       Y1,
    input  logic       G1,
    input  logic       R2,
    input  logic       Y2,
    input  logic       G2,
    input  logic       fault_clr,
    output logic       LR1,
    output logic       LY1,
    output logic       LG1,
    output logic       LR2,
    output logic       LY2,
    output logic       LG2,
    output logic       fault,
    output logic [1:0] fault_code
);

    localparam int FW = $clog2(FILTER_CYC) + 1;
    localparam int HW = $clog2(CLEAR_HOLD) + 1;
    localparam logic [5:0] ALL_RED = 6'b100_100;

    state_t      state;
    state_t      nstate;
    logic [FW-1:0] filt_cnt;
    logic [HW-1:0] hold_cnt;
    logic [1:0]  code;
    logic [1:0]  code_q;
    logic [5:0]  lamps;
    logic [5:0]  lamps_q;
    logic        all_red;
    logic        filt_hit;
    logic        hold_hit;
    logic        phase;

    assign lamps    = {R1, Y1, G1, R2, Y2, G2};
    assign code     = group_check(lamps[5:3], lamps[2:0]);
    assign all_red  = (lamps == ALL_RED);
    assign filt_hit = (filt_cnt >= FW'(FILTER_CYC - 1));
    assign hold_hit = (hold_cnt >= HW'(CLEAR_HOLD - 1));

    // Next-state decision from the current sample.
    always_comb begin
        nstate = state;
        unique case (state)
            MONITOR: if (code != NONE && filt_hit) nstate = FAULT;
            FAULT:   if (fault_clr) nstate = RECOVER;
            RECOVER: begin
                if (code != NONE)
                    nstate = FAULT;
                else if (all_red && hold_hit)
                    nstate = MONITOR;
            end
            default: nstate = MONITOR;
        endcase
    end

    // State register, filter/hold counters and latched fault code.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= MONITOR;
            filt_cnt <= '0;
            hold_cnt <= '0;
            code_q   <= NONE;
        end else begin
            state <= nstate;
            unique case (state)
                MONITOR: begin
                    if (code == NONE) begin
                        filt_cnt <= '0;
                    end else if (filt_hit) begin
                        filt_cnt <= '0;
                        code_q   <= code;
                    end else begin
                        filt_cnt <= filt_cnt + FW'(1);
                    end
                end
                FAULT: hold_cnt <= '0;
                RECOVER: begin
                    if (code != NONE) begin
                        hold_cnt <= '0;
                        code_q   <= code;
                    end else if (all_red) begin
                        if (hold_hit) begin
                            hold_cnt <= '0;
                            code_q   <= NONE;
                        end else begin
                            hold_cnt <= hold_cnt + HW'(1);
                        end
                    end else begin
                        hold_cnt <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // Output register: inputs in MONITOR, steady all-red otherwise.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            lamps_q <= ALL_RED;
        else if (nstate == MONITOR)
            lamps_q <= lamps;
        else
            lamps_q <= ALL_RED;
    end

    traffic_flasher #(
        .FLASH_HALF (FLASH_HALF)
    ) u_flasher (
        .clk   (clk),
        .rst   (rst),
        .en    (nstate == FAULT),
        .phase (phase)
    );

    assign LR1 = (state == FAULT) ? phase : lamps_q[5];
    assign LY1 = (state == FAULT) ? 1'b0  : lamps_q[4];
    assign LG1 = (state == FAULT) ? 1'b0  : lamps_q[3];
    assign LR2 = (state == FAULT) ? phase : lamps_q[2];
    assign LY2 = (state == FAULT) ? 1'b0  : lamps_q[1];
    assign LG2 = (state == FAULT) ? 1'b0  : lamps_q[0];

    assign fault      = (state != MONITOR);
    assign fault_code = code_q;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Bench for traffic_conflict_monitor: directed and random lamp
// sequences checked against a rule-level reference model.
module tb_traffic_conflict_monitor;

    localparam int FILT = 4;
    localparam int HALF = 8;
    localparam int HOLD = 16;

    logic clk = 1'b0;
    logic rst;
    logic R1, Y1, G1, R2, Y2, G2;
    logic fault_clr;
    logic LR1, LY1, LG1, LR2, LY2, LG2;
    logic fault;
    logic [1:0] fault_code;

    int total = 0;
    int bad   = 0;

    int m_mode;
    int m_filt;
    int m_hold;
    int m_code;
    int m_tin;
    logic [5:0] m_lamps;

    logic [5:0] legal_tab [5] = '{6'b001_100, 6'b010_100, 6'b100_100,
                                  6'b100_001, 6'b100_010};

    traffic_conflict_monitor #(
        .FILTER_CYC (FILT),
        .FLASH_HALF (HALF),
        .CLEAR_HOLD (HOLD)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .R1         (R1),
        .Y1         (Y1),
        .G1         (G1),
        .R2         (R2),
        .Y2         (Y2),
        .G2         (G2),
        .fault_clr  (fault_clr),
        .LR1        (LR1),
        .LY1        (LY1),
        .LG1        (LG1),
        .LR2        (LR2),
        .LY2        (LY2),
        .LG2        (LG2),
        .fault      (fault),
        .fault_code (fault_code)
    );

    always #5 clk = ~clk;

    function automatic int classify(input logic [5:0] l);
        int n1;
        int n2;
        n1 = int'(l[5]) + int'(l[4]) + int'(l[3]);
        n2 = int'(l[2]) + int'(l[1]) + int'(l[0]);
        if ((l[4] || l[3]) && (l[1] || l[0])) return 1;
        if (n1 > 1 || n2 > 1) return 2;
        if (n1 == 0 || n2 == 0) return 3;
        return 0;
    endfunction

    task automatic model_reset();
        m_mode  = 0;
        m_filt  = 0;
        m_hold  = 0;
        m_code  = 0;
        m_tin   = 0;
        m_lamps = 6'b100_100;
    endtask

    task automatic model_edge(input logic [5:0] l, input bit clr);
        int c;
        c = classify(l);
        case (m_mode)
            0: begin
                m_lamps = l;
                if (c != 0) begin
                    m_filt++;
                    if (m_filt >= FILT) begin
                        m_mode = 1;
                        m_code = c;
                        m_tin  = 0;
                        m_filt = 0;
                    end
                end else begin
                    m_filt = 0;
                end
            end
            1: begin
                if (clr) begin
                    m_mode = 2;
                    m_hold = 0;
                end else begin
                    m_tin++;
                end
            end
            default: begin
                if (c != 0) begin
                    m_mode = 1;
                    m_code = c;
                    m_tin  = 0;
                end else if (l == 6'b100_100) begin
                    m_hold++;
                    if (m_hold >= HOLD) begin
                        m_mode  = 0;
                        m_code  = 0;
                        m_hold  = 0;
                        m_lamps = l;
                    end
                end else begin
                    m_hold = 0;
                end
            end
        endcase
    endtask

    function automatic logic [8:0] model_out();
        logic lit;
        case (m_mode)
            0: return {m_lamps, 1'b0, 2'd0};
            1: begin
                lit = ((m_tin / HALF) % 2) == 0;
                return {lit, 2'b00, lit, 2'b00, 1'b1, 2'(m_code)};
            end
            default: return {6'b100_100, 1'b1, 2'(m_code)};
        endcase
    endfunction

    function automatic logic [8:0] dut_out();
        return {LR1, LY1, LG1, LR2, LY2, LG2, fault, fault_code};
    endfunction

    task automatic check(input string tag, input logic [8:0] want);
        logic [8:0] got;
        got = dut_out();
        total++;
        assert (got === want) else begin
            bad++;
            $error("FAIL %s got=%b want=%b", tag, got, want);
        end
    endtask

    task automatic step(input logic [5:0] l, input bit clr, input string tag);
        @(negedge clk);
        {R1, Y1, G1, R2, Y2, G2} = l;
        fault_clr = clr;
        @(posedge clk);
        #1;
        model_edge(l, clr);
        check(tag, model_out());
    endtask

    task automatic repeat_step(input logic [5:0] l, input int n, input string tag);
        for (int i = 0; i < n; i++) step(l, 1'b0, tag);
    endtask

    initial begin
        rst = 1'b1;
        {R1, Y1, G1, R2, Y2, G2} = 6'b000_000;
        fault_clr = 1'b0;
        model_reset();
        #12;
        check("reset", 9'b100_100_0_00);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 5; i++) step(legal_tab[i], 1'b0, "pass");
        step(6'b100_100, 1'b0, "pass");

        repeat_step(6'b001_001, FILT - 1, "glitch");
        step(6'b100_100, 1'b0, "glitch_end");
        repeat_step(6'b001_100, 3, "glitch_after");

        repeat_step(6'b001_001, FILT, "conflict");
        repeat_step(6'b001_001, 3 * HALF, "flash");
        step(6'b100_100, 1'b1, "clr");
        repeat_step(6'b100_100, HOLD, "recover");
        step(6'b010_100, 1'b0, "resume");

        repeat_step(6'b001_001, FILT, "conflict2");
        step(6'b001_001, 1'b1, "clr_illegal");
        step(6'b100_100, 1'b0, "reeval");
        repeat_step(6'b100_100, 9, "recover2");
        step(6'b110_100, 1'b0, "relatch");
        repeat_step(6'b110_100, HALF + 2, "reflash");
        step(6'b100_100, 1'b1, "clr2");
        repeat_step(6'b100_100, 5, "hold_part");
        step(6'b100_001, 1'b0, "hold_break");
        repeat_step(6'b100_100, HOLD, "recover3");

        repeat_step(6'b000_000, FILT, "dark");
        step(6'b100_100, 1'b1, "clr3");
        repeat_step(6'b100_100, HOLD, "recover4");
        repeat_step(6'b110_100, FILT, "multi");
        step(6'b100_100, 1'b1, "clr4");
        repeat_step(6'b100_100, HOLD, "recover5");

        for (int s = 0; s < 120; s++) begin
            int kind;
            int n;
            kind = $urandom_range(0, 3);
            case (kind)
                0: begin
                    n = $urandom_range(1, 8);
                    for (int i = 0; i < n; i++)
                        step(legal_tab[$urandom_range(0, 4)],
                             1'($urandom_range(0, 1)), "rnd_legal");
                end
                1: begin
                    n = $urandom_range(1, 6);
                    for (int i = 0; i < n; i++)
                        step(6'($urandom_range(0, 63)),
                             1'($urandom_range(0, 4) == 0), "rnd_illegal");
                end
                2: begin
                    n = $urandom_range(10, 20);
                    step(6'b100_100, 1'b1, "rnd_clr");
                    repeat_step(6'b100_100, n, "rnd_red");
                end
                default: begin
                    n = $urandom_range(1, 10);
                    for (int i = 0; i < n; i++)
                        step(6'($urandom_range(0, 63)),
                             1'($urandom_range(0, 1)), "rnd_mix");
                end
            endcase
        end

        step(6'b100_100, 1'b1, "pre_rst");
        repeat_step(6'b100_100, HOLD, "pre_rst");
        repeat_step(6'b001_001, FILT, "rst_fault");
        repeat_step(6'b001_001, HALF + 3, "rst_flash");
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst", 9'b100_100_0_00);
        model_reset();
        @(posedge clk);
        #1;
        check("rst_hold", 9'b100_100_0_00);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 5; i++) step(legal_tab[i], 1'b0, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
